vpu_dst_port: RTL and testbench

- Destination-side port of the VPU datapath. It collects per-element results from one execution unit (done pulse plus result word) after the source port has issued a vector operation.
- Packs the results into LANES-wide writeback beats, buffers the beats in a small FIFO, and writes them to the vector register file over a valid/ready interface.
- Execution units have fixed latency and no backpressure, so this block must absorb every done pulse. It reports free buffer space so the source port can throttle issue.

---
 rtl/vpu_dst_port_if.sv | 39 +++
 rtl/vpu_dst_port.sv | 144 ++++++++++++++
 tb/tb_vpu_dst_port.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vpu_dst_port_if.sv
// Bundle of descriptor, result and writeback signals for vpu_dst_port.
// slave = the port itself, master = the surrounding VPU / register file side.
interface vpu_dst_port_if #(
  parameter int OPERAND_WIDTH  = 32,
  parameter int LANES          = 4,
  parameter int FIFO_DEPTH_LG2 = 2,
  parameter int ADDR_WIDTH     = 5
);
  logic                             cmd_valid_i;
  logic                             cmd_ready_o;
  logic [ADDR_WIDTH-1:0]            cmd_addr_i;
  logic [7:0]                       cmd_len_i;
  logic                             done_i;
  logic [OPERAND_WIDTH-1:0]         result_i;
  logic                             wb_valid_o;
  logic                             wb_ready_i;
  logic [ADDR_WIDTH-1:0]            wb_addr_o;
  logic [LANES*OPERAND_WIDTH-1:0]   wb_data_o;
  logic [LANES-1:0]                 wb_mask_o;
  logic                             wb_last_o;
  logic [FIFO_DEPTH_LG2:0]          fifo_free_o;
  logic                             busy_o;
  logic                             overflow_o;

  // cmd and wb are valid/ready: a transfer happens on a rising edge where both are high;
  // once valid is raised, valid and payload stay stable until ready is seen.
  // done_i/result_i carry no ready: every done pulse must be absorbed.
  modport slave (
    input  cmd_valid_i, cmd_addr_i, cmd_len_i, done_i, result_i, wb_ready_i,
    output cmd_ready_o, wb_valid_o, wb_addr_o, wb_data_o, wb_mask_o, wb_last_o,
           fifo_free_o, busy_o, overflow_o
  );

  modport master (
    output cmd_valid_i, cmd_addr_i, cmd_len_i, done_i, result_i, wb_ready_i,
    input  cmd_ready_o, wb_valid_o, wb_addr_o, wb_data_o, wb_mask_o, wb_last_o,
           fifo_free_o, busy_o, overflow_o
  );
endinterface

// File: rtl/vpu_dst_port.sv
// VPU destination port: packs per-element results into LANES-wide beats and writes them back via a beat FIFO.
// Optional macro VPU_DST_PORT_ZERO_FILL_EN forces unmasked lanes of every beat to zero.
module vpu_dst_port #(
  parameter int OPERAND_WIDTH  = 32,
  parameter int LANES          = 4,
  parameter int FIFO_DEPTH_LG2 = 2,
  parameter int ADDR_WIDTH     = 5
) (
  input  logic          clk,
  input  logic          rst,
  vpu_dst_port_if.slave bus,
  output logic [1:0]    state_dbg
);
  localparam int LANE_W = $clog2(LANES);
  localparam int DEPTH  = 1 << FIFO_DEPTH_LG2;
  localparam int OCC_W  = FIFO_DEPTH_LG2 + 1;
  localparam int DATA_W = LANES * OPERAND_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DRAIN = 2'd2} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]     cur_addr;
  logic [7:0]                len_q, elem_cnt, elem_inc;
  logic [LANE_W-1:0]         lane_idx;
  logic [DATA_W-1:0]         pack_q, pack_nxt, push_data;
  logic [LANES-1:0]          mask_q, mask_nxt;

  logic [DATA_W-1:0]         data_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]     addr_mem [DEPTH];
  logic [LANES-1:0]          mask_mem [DEPTH];
  logic                      last_mem [DEPTH];
  logic [FIFO_DEPTH_LG2-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0]          occ, occ_nxt, free_q;
  logic                      valid_q, overflow_q;

  logic cmd_fire, collect, stray_done, at_last, push_req, push_ok, pop, full;

  always_comb begin
    cmd_fire   = bus.cmd_valid_i && (state == IDLE);
    collect    = bus.done_i && (state == COLLECT);
    stray_done = bus.done_i && (state != COLLECT);
    elem_inc   = elem_cnt + 8'd1;
    at_last    = (elem_inc == len_q);
    pack_nxt   = pack_q;
    for (int l = 0; l < LANES; l++) begin
      if (lane_idx == LANE_W'(l)) pack_nxt[l*OPERAND_WIDTH +: OPERAND_WIDTH] = bus.result_i;
    end
    mask_nxt  = mask_q | (LANES'(1) << lane_idx);
    push_data = pack_nxt;
`ifdef VPU_DST_PORT_ZERO_FILL_EN
    for (int l = 0; l < LANES; l++) begin
      if (!mask_nxt[l]) push_data[l*OPERAND_WIDTH +: OPERAND_WIDTH] = '0;
    end
`endif
    push_req = collect && ((lane_idx == LANE_W'(LANES - 1)) || at_last);
    pop      = valid_q && bus.wb_ready_i;
    full     = (occ == OCC_W'(DEPTH));
    // A full FIFO still takes the beat when the head leaves in the same cycle.
    push_ok  = push_req && (!full || pop);
    occ_nxt  = occ + OCC_W'(push_ok) - OCC_W'(pop);

    state_nxt = state;
    case (state)
      IDLE:    if (cmd_fire) state_nxt = COLLECT;
      COLLECT: if (push_req && at_last) state_nxt = DRAIN;
      DRAIN:   if (!valid_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_addr   <= '0;
      len_q      <= 8'd1;
      elem_cnt   <= '0;
      lane_idx   <= '0;
      pack_q     <= '0;
      mask_q     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      free_q     <= OCC_W'(DEPTH);
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        addr_mem[i] <= '0;
        mask_mem[i] <= '0;
        last_mem[i] <= 1'b0;
      end
    end else begin
      state <= state_nxt;
      if (cmd_fire) begin
        cur_addr <= bus.cmd_addr_i;
        len_q    <= (bus.cmd_len_i == 8'd0) ? 8'd1 : bus.cmd_len_i;
        elem_cnt <= '0;
        lane_idx <= '0;
        mask_q   <= '0;
      end
      if (collect) begin
        elem_cnt <= elem_inc;
        if (push_req) begin
          cur_addr <= cur_addr + ADDR_WIDTH'(1);
          lane_idx <= '0;
          mask_q   <= '0;
`ifdef VPU_DST_PORT_ZERO_FILL_EN
          pack_q   <= '0;
`else
          pack_q   <= pack_nxt;
`endif
        end else begin
          lane_idx <= lane_idx + LANE_W'(1);
          mask_q   <= mask_nxt;
          pack_q   <= pack_nxt;
        end
      end
      // A dropped beat or a result arriving outside an op is unrecoverable; flag it until reset.
      if (stray_done || (push_req && !push_ok)) overflow_q <= 1'b1;
      if (push_ok) begin
        data_mem[wr_ptr] <= push_data;
        addr_mem[wr_ptr] <= cur_addr;
        mask_mem[wr_ptr] <= mask_nxt;
        last_mem[wr_ptr] <= at_last;
        wr_ptr           <= wr_ptr + FIFO_DEPTH_LG2'(1);
      end
      if (pop) rd_ptr <= rd_ptr + FIFO_DEPTH_LG2'(1);
      occ     <= occ_nxt;
      valid_q <= (occ_nxt != '0);
      free_q  <= OCC_W'(DEPTH) - occ_nxt;
    end
  end

  assign bus.cmd_ready_o = (state == IDLE);
  assign bus.busy_o      = (state != IDLE);
  assign bus.wb_valid_o  = valid_q;
  assign bus.wb_addr_o   = addr_mem[rd_ptr];
  assign bus.wb_data_o   = data_mem[rd_ptr];
  assign bus.wb_mask_o   = mask_mem[rd_ptr];
  assign bus.wb_last_o   = last_mem[rd_ptr];
  assign bus.fifo_free_o = free_q;
  assign bus.overflow_o  = overflow_q;
  assign state_dbg       = state;
endmodule

// File: tb/tb_vpu_dst_port.sv
// Directed bench for vpu_dst_port: packing, partial beats, backpressure, overflow, reset and address wrap.
module tb_vpu_dst_port;
  localparam int BW = 1 + 5 + 4 + 128;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;
  int         passed = 0;
  int         total  = 0;

  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] obs_q[$];

  vpu_dst_port_if #(.OPERAND_WIDTH(32), .LANES(4), .FIFO_DEPTH_LG2(2), .ADDR_WIDTH(5)) bus ();

  vpu_dst_port #(.OPERAND_WIDTH(32), .LANES(4), .FIFO_DEPTH_LG2(2), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [127:0] keep_masked(input logic [127:0] d, input logic [3:0] m);
    logic [127:0] r = d;
`ifndef VPU_DST_PORT_ZERO_FILL_EN
    for (int l = 0; l < 4; l++) if (!m[l]) r[l*32 +: 32] = '0;
`endif
    return r;
  endfunction

  function automatic logic [BW-1:0] mk_beat(input logic [4:0] addr, input logic [3:0] mask,
                                            input logic last, input logic [31:0] first);
    logic [127:0] d = '0;
    for (int l = 0; l < 4; l++) if (mask[l]) d[l*32 +: 32] = first + 32'(l);
    return {last, addr, mask, d};
  endfunction

  // Writeback monitor: records every accepted beat.
  always @(posedge clk) begin
    if (!rst && bus.wb_valid_o && bus.wb_ready_i)
      obs_q.push_back({bus.wb_last_o, bus.wb_addr_o, bus.wb_mask_o,
                       keep_masked(bus.wb_data_o, bus.wb_mask_o)});
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_sb(input string tag);
    chk({tag, "_beat_count"}, BW'(obs_q.size()), BW'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_beat"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.cmd_ready_o !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk(tag, BW'(bus.cmd_ready_o), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cmd_valid_i = 1'b0;
    bus.done_i      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Leaves the bench at the negedge right after the descriptor was accepted.
  task automatic start(input logic [4:0] addr, input logic [7:0] len);
    tick();
    bus.cmd_valid_i = 1'b1;
    bus.cmd_addr_i  = addr;
    bus.cmd_len_i   = len;
    tick();
    bus.cmd_valid_i = 1'b0;
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_addr_i  = '0;
    bus.cmd_len_i   = '0;
    bus.done_i      = 1'b0;
    bus.result_i    = '0;
    bus.wb_ready_i  = 1'b1;
    do_reset();

    chk("rst_cmd_ready", BW'(bus.cmd_ready_o), 1);
    chk("rst_wb_valid", BW'(bus.wb_valid_o), 0);
    chk("rst_busy", BW'(bus.busy_o), 0);
    chk("rst_overflow", BW'(bus.overflow_o), 0);
    chk("rst_free", BW'(bus.fifo_free_o), 4);
    chk("rst_wb_addr", BW'(bus.wb_addr_o), 0);
    chk("rst_wb_data", BW'(bus.wb_data_o), 0);
    chk("rst_wb_mask", BW'(bus.wb_mask_o), 0);
    chk("rst_wb_last", BW'(bus.wb_last_o), 0);
    chk("rst_state", BW'(state_dbg), 0);

    // Two full beats, no backpressure.
    exp_q.push_back(mk_beat(5'd3, 4'hf, 1'b0, 32'h1));
    exp_q.push_back(mk_beat(5'd4, 4'hf, 1'b1, 32'h5));
    start(5'd3, 8'd8);
    chk("t1_busy", BW'(bus.busy_o), 1);
    chk("t1_cmd_ready_low", BW'(bus.cmd_ready_o), 0);
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) tick();
      if (i == 5) begin
        chk("t1_beat0_valid", BW'(bus.wb_valid_o), 1);
        chk("t1_beat0_addr", BW'(bus.wb_addr_o), 3);
        chk("t1_beat0_free", BW'(bus.fifo_free_o), 3);
      end
      bus.done_i   = 1'b1;
      bus.result_i = 32'(i);
    end
    tick();
    bus.done_i = 1'b0;
    chk("t1_last_valid", BW'(bus.wb_valid_o), 1);
    chk("t1_last_flag", BW'(bus.wb_last_o), 1);
    chk("t1_last_addr", BW'(bus.wb_addr_o), 4);
    chk("t1_state_drain", BW'(state_dbg), 2);
    tick();
    chk("t1_empty", BW'(bus.wb_valid_o), 0);
    chk("t1_still_busy", BW'(bus.busy_o), 1);
    chk("t1_free_back", BW'(bus.fifo_free_o), 4);
    tick();
    chk("t1_idle_busy", BW'(bus.busy_o), 0);
    chk("t1_idle_ready", BW'(bus.cmd_ready_o), 1);
    check_sb("t1");

    // Partial final beat.
    exp_q.push_back(mk_beat(5'd10, 4'hf, 1'b0, 32'hA));
    exp_q.push_back(mk_beat(5'd11, 4'h3, 1'b1, 32'hE));
    start(5'd10, 8'd6);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      bus.done_i   = 1'b1;
      bus.result_i = 32'hA + 32'(i);
    end
    tick();
    bus.done_i = 1'b0;
    chk("t2_mask", BW'(bus.wb_mask_o), 4'h3);
    chk("t2_last", BW'(bus.wb_last_o), 1);
    chk("t2_addr", BW'(bus.wb_addr_o), 11);
    wait_idle("t2_idle");
    check_sb("t2");

    // Backpressure: FIFO fills exactly, no overflow.
    bus.wb_ready_i = 1'b0;
    for (int b = 0; b < 4; b++)
      exp_q.push_back(mk_beat(5'(20 + b), 4'hf, 1'(b == 3), 32'h100 + 32'(4 * b)));
    start(5'd20, 8'd16);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      if (i % 4 == 0) chk($sformatf("t3_free_%0d", i), BW'(bus.fifo_free_o), BW'(4 - i / 4));
      bus.done_i   = 1'b1;
      bus.result_i = 32'h100 + 32'(i);
    end
    tick();
    bus.done_i = 1'b0;
    chk("t3_free_full", BW'(bus.fifo_free_o), 0);
    chk("t3_no_overflow", BW'(bus.overflow_o), 0);
    chk("t3_head_addr", BW'(bus.wb_addr_o), 20);
    bus.wb_ready_i = 1'b1;
    wait_idle("t3_idle");
    check_sb("t3");

    // Overflow: fifth beat is dropped.
    bus.wb_ready_i = 1'b0;
    for (int b = 0; b < 4; b++)
      exp_q.push_back(mk_beat(5'(28 + b), 4'hf, 1'b0, 32'h200 + 32'(4 * b)));
    start(5'd28, 8'd20);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) tick();
      if (i == 19) chk("t4_pre_overflow", BW'(bus.overflow_o), 0);
      bus.done_i   = 1'b1;
      bus.result_i = 32'h200 + 32'(i);
    end
    tick();
    bus.done_i = 1'b0;
    chk("t4_overflow", BW'(bus.overflow_o), 1);
    chk("t4_state_drain", BW'(state_dbg), 2);
    bus.wb_ready_i = 1'b1;
    wait_idle("t4_idle");
    chk("t4_overflow_sticky", BW'(bus.overflow_o), 1);
    check_sb("t4");

    // Spurious done in IDLE.
    do_reset();
    chk("t5_overflow_cleared", BW'(bus.overflow_o), 0);
    tick();
    bus.done_i   = 1'b1;
    bus.result_i = 32'hDEAD;
    tick();
    bus.done_i = 1'b0;
    chk("t5_overflow", BW'(bus.overflow_o), 1);
    chk("t5_free", BW'(bus.fifo_free_o), 4);
    chk("t5_no_push", BW'(bus.wb_valid_o), 0);
    chk("t5_ready", BW'(bus.cmd_ready_o), 1);
    check_sb("t5");

    // Reset in the middle of an op.
    start(5'd5, 8'd8);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      bus.done_i   = 1'b1;
      bus.result_i = 32'h20 + 32'(i);
    end
    tick();
    bus.done_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_wb_valid", BW'(bus.wb_valid_o), 0);
    chk("t6_free", BW'(bus.fifo_free_o), 4);
    chk("t6_ready", BW'(bus.cmd_ready_o), 1);
    chk("t6_overflow", BW'(bus.overflow_o), 0);
    chk("t6_state", BW'(state_dbg), 0);
    exp_q.push_back(mk_beat(5'd7, 4'hf, 1'b1, 32'h30));
    start(5'd7, 8'd4);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      bus.done_i   = 1'b1;
      bus.result_i = 32'h30 + 32'(i);
    end
    tick();
    bus.done_i = 1'b0;
    wait_idle("t6_idle");
    check_sb("t6");

    // len=0 acts as one element.
    exp_q.push_back(mk_beat(5'd31, 4'h1, 1'b1, 32'h55));
    start(5'd31, 8'd0);
    bus.done_i   = 1'b1;
    bus.result_i = 32'h55;
    tick();
    bus.done_i = 1'b0;
    wait_idle("t7_idle");
    check_sb("t7");

    // Beat address wraps past 31.
    exp_q.push_back(mk_beat(5'd31, 4'hf, 1'b0, 32'h60));
    exp_q.push_back(mk_beat(5'd0, 4'h1, 1'b1, 32'h64));
    start(5'd31, 8'd5);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      bus.done_i   = 1'b1;
      bus.result_i = 32'h60 + 32'(i);
    end
    tick();
    bus.done_i = 1'b0;
    wait_idle("t8_idle");
    chk("t8_no_overflow", BW'(bus.overflow_o), 0);
    check_sb("t8");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
